// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline memory path: read-ownership encoding and word width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } mem_owner_t;

  localparam int INST_W = 16;

endpackage

// File: rtl/pipeline_mem_arbiter_if.sv
// Fetch, data and RAM signal bundle around the memory arbiter.
// Handshake: req is held until gnt; gnt marks the issue cycle; rvalid follows a read grant by one cycle.
interface pipeline_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pipeline_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and the ld/st port, with
// fetch anti-starvation and read-return steering by in-flight owner.
module pipeline_mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = INST_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  pipeline_mem_arbiter_if.slave               bus,
  output mem_owner_t                          dbg_owner,
  output logic [$clog2(STARVE_MAX+1)-1:0]     dbg_starve
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  mem_owner_t       owner, owner_nxt;
  logic [CNT_W-1:0] starve, starve_nxt;
  logic             fetch_wins;
  logic             if_gnt, d_gnt;

  // Fetch only overrides data once it has been denied STARVE_MAX cycles in a row.
  assign fetch_wins = (starve == CNT_W'(STARVE_MAX));
  assign if_gnt = ~reset & bus.if_req & ~bus.if_flush & (~bus.d_req | fetch_wins);
  assign d_gnt  = ~reset & bus.d_req & ~if_gnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner  <= OWN_NONE;
      starve <= '0;
    end else begin
      owner  <= owner_nxt;
      starve <= starve_nxt;
    end
  end

  always_comb begin
    owner_nxt  = OWN_NONE;
    starve_nxt = starve;
    if (if_gnt)
      owner_nxt = OWN_IF;
    else if (d_gnt && !bus.d_we)
      owner_nxt = OWN_DATA;

    if (if_gnt || !bus.if_req || bus.if_flush)
      starve_nxt = '0;
    else if (!fetch_wins)
      starve_nxt = starve + 1'b1;
  end

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.mem_en    = if_gnt | d_gnt;
  assign bus.mem_we    = d_gnt & bus.d_we;
  assign bus.mem_addr  = if_gnt ? bus.if_addr : (d_gnt ? bus.d_addr : '0);
  assign bus.mem_wdata = d_gnt ? bus.d_wdata : '0;

  // A flush kills fetch data already on its way back from the RAM.
  assign bus.if_rvalid = ~reset & (owner == OWN_IF) & ~bus.if_flush;
  assign bus.d_rvalid  = ~reset & (owner == OWN_DATA);
  assign bus.if_rdata  = reset ? '0 : bus.mem_rdata;
  assign bus.d_rdata   = reset ? '0 : bus.mem_rdata;

  assign dbg_owner  = owner;
  assign dbg_starve = starve;

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with a behavioural RAM and a
// scoreboard that matches returned read data against expected queues.
module tb_pipeline_mem_arbiter;
  import pipeline_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  mem_owner_t dbg_owner;
  logic [2:0] dbg_starve;

  int total = 0;
  int bad   = 0;

  logic [15:0] if_exp_q[$];
  logic [15:0] d_exp_q[$];

  pipeline_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  pipeline_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_owner  (dbg_owner),
    .dbg_starve (dbg_starve)
  );

  // clock / reset
  always #5 clk = ~clk;

  // behavioural single-port RAM, 1-cycle read latency; contents default to 16'h3000 + addr
  logic [15:0] ram [0:255];
  logic [15:0] ram_rd;
  bit          ram_init = 1'b0;
  assign bus.mem_rdata = ram_rd;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'h3000 + 16'(i);
      ram[8'h10] <= 16'hA5A5;
      ram[8'h40] <= 16'hBEEF;
      ram_init   <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
      else            ram_rd <= ram[bus.mem_addr[7:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: samples exactly at negedge, before the driver pushes for the same cycle
  always @(negedge clk) begin
    if (bus.if_rvalid === 1'b1) begin
      if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 1, 0);
      else check("if_rdata", bus.if_rdata, if_exp_q.pop_front());
    end
    if (bus.d_rvalid === 1'b1) begin
      if (d_exp_q.size() == 0) check("d_rvalid_unexpected", 1, 0);
      else check("d_rdata", bus.d_rdata, d_exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.if_flush = 1'b0;
    bus.d_req    = 1'b0;
    bus.d_we     = 1'b0;
    bus.d_addr   = '0;
    bus.d_wdata  = '0;
  endtask

  task automatic load_req(input logic [15:0] addr);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = addr;
  endtask

  int k;

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    sample();
    check("rst_if_gnt", bus.if_gnt, 0);
    check("rst_d_gnt", bus.d_gnt, 0);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_owner", dbg_owner, OWN_NONE);
    check("rst_starve", dbg_starve, 0);
    step();
    reset = 1'b0;
    idle_inputs();

    // 1: plain fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0010;
    sample();
    check("t1_if_gnt", bus.if_gnt, 1);
    check("t1_mem_addr", bus.mem_addr, 16'h0010);
    check("t1_mem_en", bus.mem_en, 1);
    check("t1_mem_we", bus.mem_we, 0);
    if_exp_q.push_back(16'hA5A5);
    step();
    idle_inputs();
    sample();
    check("t1_owner", dbg_owner, OWN_IF);
    step();

    // 2: data beats fetch, fetch follows when d_req drops
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0014;
    load_req(16'h0040);
    sample();
    check("t2_d_gnt", bus.d_gnt, 1);
    check("t2_if_gnt", bus.if_gnt, 0);
    check("t2_mem_addr", bus.mem_addr, 16'h0040);
    d_exp_q.push_back(16'hBEEF);
    step();
    bus.d_req = 1'b0;
    sample();
    check("t2_if_gnt_after", bus.if_gnt, 1);
    check("t2_mem_addr_after", bus.mem_addr, 16'h0014);
    if_exp_q.push_back(16'h3014);
    step();
    idle_inputs();
    step();

    // 3: starvation, fetch forced through every fifth cycle
    k = 0;
    for (int c = 0; c < 10; c++) begin
      bus.if_req  = 1'b1;
      bus.if_addr = 16'h0050;
      load_req(16'h0020 + 16'(k));
      sample();
      check("t3_starve", dbg_starve, c % 5);
      if (c % 5 == 4) begin
        check("t3_if_gnt_forced", bus.if_gnt, 1);
        check("t3_d_gnt_held", bus.d_gnt, 0);
        if_exp_q.push_back(16'h3050);
      end else begin
        check("t3_if_gnt_denied", bus.if_gnt, 0);
        check("t3_d_gnt", bus.d_gnt, 1);
        d_exp_q.push_back(16'h3020 + 16'(k));
        k++;
      end
      step();
    end
    idle_inputs();
    step();

    // 4: store then load of the same address
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 16'h0080;
    bus.d_wdata = 16'h1234;
    sample();
    check("t4_mem_en", bus.mem_en, 1);
    check("t4_mem_we", bus.mem_we, 1);
    check("t4_mem_wdata", bus.mem_wdata, 16'h1234);
    check("t4_mem_addr", bus.mem_addr, 16'h0080);
    step();
    bus.d_wdata = '0;
    load_req(16'h0080);
    sample();
    check("t4_no_rvalid", bus.d_rvalid, 0);
    check("t4_owner_none", dbg_owner, OWN_NONE);
    check("t4_load_gnt", bus.d_gnt, 1);
    check("t4_load_we", bus.mem_we, 0);
    d_exp_q.push_back(16'h1234);
    step();
    idle_inputs();
    step();

    // 5: flush the cycle after a fetch grant
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0060;
    sample();
    check("t5_if_gnt", bus.if_gnt, 1);
    step();
    bus.if_addr  = 16'h0064;
    bus.if_flush = 1'b1;
    sample();
    check("t5_flush_rvalid", bus.if_rvalid, 0);
    check("t5_flush_gnt", bus.if_gnt, 0);
    check("t5_flush_mem_en", bus.mem_en, 0);
    step();
    idle_inputs();
    sample();
    check("t5_starve_clear", dbg_starve, 0);
    check("t5_owner_none", dbg_owner, OWN_NONE);
    step();

    // 6: reset during an in-flight load
    load_req(16'h0040);
    sample();
    check("t6_d_gnt", bus.d_gnt, 1);
    step();
    reset       = 1'b1;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0070;
    bus.d_wdata = 16'hFFFF;
    sample();
    check("t6_rst_d_rvalid", bus.d_rvalid, 0);
    check("t6_rst_mem_en", bus.mem_en, 0);
    check("t6_rst_mem_we", bus.mem_we, 0);
    check("t6_rst_mem_addr", bus.mem_addr, 0);
    check("t6_rst_mem_wdata", bus.mem_wdata, 0);
    check("t6_rst_if_gnt", bus.if_gnt, 0);
    check("t6_rst_d_rdata", bus.d_rdata, 0);
    check("t6_rst_owner", dbg_owner, OWN_NONE);
    step();
    reset = 1'b0;
    idle_inputs();
    load_req(16'h0044);
    sample();
    check("t6_post_d_gnt", bus.d_gnt, 1);
    check("t6_post_mem_addr", bus.mem_addr, 16'h0044);
    d_exp_q.push_back(16'h3044);
    step();
    idle_inputs();
    repeat (3) step();

    check("if_queue_drained", if_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
